// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall masks, exception vector default and FSM encoding shared by the pipeline controller.
package pipe_ctrl_pkg;
  typedef enum logic {IDLE, FLUSH} state_e;
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EXE  = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;
  function automatic logic [5:0] stall_mask(input logic mem, input logic exe, input logic id);
    return mem ? STALL_MEM : exe ? STALL_EXE : id ? STALL_ID : STALL_NONE;
  endfunction
endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);
  logic [W-1:0] value_q, value_d;
  always_comb value_d = clr ? '0 : (inc && value_q != '1) ? value_q + W'(1) : value_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) value_q <= '0;
    else value_q <= value_d;
  assign value = value_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with exception/ERET redirect, stall statistics and hang detection.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int unsigned HANG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallreq_id,
  input  logic        stallreq_exe,
  input  logic        stallreq_mem,
  input  logic        except_valid,
  input  logic        eret,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic        hang
);
  localparam logic [31:0] RUN_TOP = 32'(HANG_LIMIT - 1);
  state_e      state_q, state_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        hang_q, hang_d;
  logic [31:0] run;
  logic        stall_any;
  // A flush cycle outranks every stall request, and reset forces the mask open.
  assign stall = (!reset || state_q == FLUSH) ? STALL_NONE
               : stall_mask(stallreq_mem, stallreq_exe, stallreq_id);
  assign stall_any = |stall;
  always_comb begin
    state_d  = (state_q == IDLE && (except_valid || eret)) ? FLUSH : IDLE;
    flush_d  = state_d == FLUSH;
    new_pc_d = flush_d ? (except_valid ? EXC_VECTOR : cp0_epc) : new_pc_q;
    hang_d   = hang_q | (stall_any && run >= RUN_TOP);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= IDLE;
      flush_q  <= 1'b0;
      new_pc_q <= 32'h0;
      hang_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
      hang_q   <= hang_d;
    end
  assign flush  = flush_q;
  assign new_pc = new_pc_q;
  assign hang   = hang_q;
  sat_counter #(.W(32)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(stall_any), .clr(1'b0), .value(stall_cycles)
  );
  // Consecutive-stall run; any open cycle (including the flush cycle) restarts it.
  sat_counter #(.W(32)) u_run_cnt (
    .clk(clk), .reset(reset), .inc(stall_any), .clr(!stall_any), .value(run)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: random and directed stimulus checked every cycle against a behavioural model of the controller.
module tb_pipe_ctrl;
  localparam logic [31:0] EXC = 32'hBFC00380;
  localparam int LIMIT = 1024;
  logic        clk = 0, reset = 0;
  logic        stallreq_id = 0, stallreq_exe = 0, stallreq_mem = 0;
  logic        except_valid = 0, eret = 0;
  logic [31:0] cp0_epc = 0;
  logic [5:0]  stall;
  logic        flush, hang;
  logic [31:0] new_pc, stall_cycles;
  int n_cmp = 0, n_bad = 0;

  pipe_ctrl #(.EXC_VECTOR(EXC), .HANG_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .stallreq_id(stallreq_id), .stallreq_exe(stallreq_exe),
    .stallreq_mem(stallreq_mem), .except_valid(except_valid), .eret(eret), .cp0_epc(cp0_epc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .stall_cycles(stall_cycles), .hang(hang)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: current-cycle flush flag, last redirect, totals and run length.
  bit      m_flush;
  logic [31:0] m_pc;
  longint  m_sc, m_run;
  bit      m_hang;

  function automatic logic [5:0] exp_stall();
    if (!reset || m_flush) return 6'h00;
    if (stallreq_mem) return 6'h1F;
    if (stallreq_exe) return 6'h0F;
    if (stallreq_id) return 6'h07;
    return 6'h00;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_flush = 0; m_pc = 0; m_sc = 0; m_run = 0; m_hang = 0;
    end else begin
      if (exp_stall() != 0) begin
        if (m_sc < 64'hFFFF_FFFF) m_sc++;
        m_run++;
        if (m_run >= LIMIT) m_hang = 1;
      end else m_run = 0;
      if (m_flush) m_flush = 0;
      else if (except_valid || eret) begin
        m_flush = 1;
        m_pc = except_valid ? EXC : cp0_epc;
      end
    end
  end

  always @(negedge clk) begin
    chk("stall", 32'(stall), 32'(exp_stall()));
    chk("flush", 32'(flush), 32'(m_flush));
    chk("new_pc", new_pc, m_pc);
    chk("stall_cycles", stall_cycles, m_sc[31:0]);
    chk("hang", 32'(hang), 32'(m_hang));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {stallreq_id, stallreq_exe, stallreq_mem, except_valid, eret} = '0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1;
    step();
    // single-cycle load-use stall
    stallreq_id = 1; #1;
    chk("id_mask", 32'(stall), 32'h07);
    step(); stallreq_id = 0; #1;
    chk("id_released", 32'(stall), 32'h00);
    chk("id_count", stall_cycles, 32'd1);
    // priority mem > exe > id
    {stallreq_id, stallreq_exe, stallreq_mem} = 3'b111; #1;
    chk("all_mask", 32'(stall), 32'h1F);
    step(); stallreq_mem = 0; #1;
    chk("drop_mem", 32'(stall), 32'h0F);
    step(); idle_inputs();
    // simultaneous exception and eret: exception vector wins
    step(); except_valid = 1; eret = 1; cp0_epc = 32'h80001000;
    step(); idle_inputs(); #1;
    chk("exc_flush", 32'(flush), 32'd1);
    chk("exc_pc", new_pc, EXC);
    chk("exc_stall", 32'(stall), 32'h00);
    step(); #1;
    chk("exc_flush_end", 32'(flush), 32'd0);
    chk("exc_pc_hold", new_pc, EXC);
    // eret overrides a held memory stall for exactly one cycle
    eret = 1; stallreq_mem = 1; cp0_epc = 32'h80001000;
    step(); eret = 0; #1;
    chk("eret_flush", 32'(flush), 32'd1);
    chk("eret_pc", new_pc, 32'h80001000);
    chk("eret_stall", 32'(stall), 32'h00);
    step(); #1;
    chk("eret_after", 32'(stall), 32'h1F);
    chk("eret_after_flush", 32'(flush), 32'd0);
    idle_inputs();
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step();
      stallreq_id  = ($urandom_range(0, 3) == 0);
      stallreq_exe = ($urandom_range(0, 4) == 0);
      stallreq_mem = ($urandom_range(0, 5) == 0);
      except_valid = ($urandom_range(0, 9) == 0);
      eret         = ($urandom_range(0, 9) == 0);
      cp0_epc      = $urandom;
    end
    step(); idle_inputs();
    // fresh reset, then hang detection on a long EXE stall
    step(); reset = 0;
    step(); reset = 1;
    step(); stallreq_exe = 1;
    repeat (LIMIT - 1) step();
    #1 chk("hang_before", 32'(hang), 32'd0);
    step(); #1;
    chk("hang_set", 32'(hang), 32'd1);
    stallreq_exe = 0;
    repeat (3) step();
    #1 chk("hang_sticky", 32'(hang), 32'd1);
    // reset in the middle of a flush cycle
    except_valid = 1;
    step(); except_valid = 0; stallreq_mem = 1; #1;
    chk("mid_flush", 32'(flush), 32'd1);
    #1 reset = 0; #1;
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_pc", new_pc, 32'h0);
    chk("rst_count", stall_cycles, 32'h0);
    chk("rst_hang", 32'(hang), 32'd0);
    chk("rst_stall", 32'(stall), 32'h00);
    step(); step(); reset = 1; idle_inputs();
    repeat (3) step();
    #1 chk("post_rst_flush", 32'(flush), 32'd0);
    repeat (2) @(posedge clk);
    #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
